// File: rtl/fir_mac_seq.sv
// Time-multiplexed Q15 FIR: one tap per clock through a single multiplier and a
// 16-bit wrapping accumulator, with a valid/ready handshake on each side.
module fir_tap (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift,
  input  logic [15:0] din,
  input  logic        cwe,
  input  logic [15:0] cdin,
  output logic [15:0] x,
  output logic [15:0] c
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      c <= '0;
    end else begin
      if (shift) x <= din;
      if (cwe)   c <= cdin;
    end
  end
endmodule

module fir_mac_seq #(
  parameter int TAPS = 8,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nxt;

  logic [TAPS-1:0][15:0] xv, cv, xin;
  logic [AW-1:0]         idx;
  logic [15:0]           acc, sum;
  logic signed [30:0]    prod;
  logic                  accept, coef_wr, last;

  assign accept  = (state == IDLE) && in_valid;
  assign coef_wr = (state == IDLE) && coef_we;
  assign last    = (idx == AW'(TAPS - 1));
  assign xin     = {xv[TAPS-2:0], in_data};

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    fir_tap u_tap (
      .clk   (clk),
      .rst_n (rst_n),
      .shift (accept),
      .din   (xin[k]),
      .cwe   (coef_wr && (coef_addr == AW'(k))),
      .cdin  (coef_wdata),
      .x     (xv[k]),
      .c     (cv[k])
    );
  end

  // Only product bits [30:15] matter; bit 31 is discarded by design.
  assign prod = $signed(cv[idx]) * $signed(xv[idx]);
  assign sum  = acc + prod[30:15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = MAC;
      MAC:     if (last)      state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      MAC:     busy     = 1'b1;
      OUT:     busy     = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= sum;
          idx <= idx + AW'(1);
          if (last) begin
            out_data  <= sum;
            out_valid <= 1'b1;
          end
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: a reference model computes each output when
// the sample is accepted; the monitor compares on the output handshake.
module tb_fir_mac_seq;
  localparam int TAPS = 8;
  localparam int AW   = 3;

  logic          clk = 0, rst_n = 0;
  logic          coef_we = 0, in_valid = 0, out_ready = 1;
  logic [AW-1:0] coef_addr = '0;
  logic [15:0]   coef_wdata = '0, in_data = '0;
  logic          in_ready, out_valid, busy;
  logic [15:0]   out_data;

  fir_mac_seq #(.TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, edge_cnt = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] mx[TAPS], mc[TAPS];
  logic        pv = 0;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out();
    longint s = 0;
    for (int k = 0; k < TAPS; k++)
      s += (longint'($signed(mc[k])) * longint'($signed(mx[k]))) >>> 15;
    return s[15:0];
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // out_valid must first be seen after acceptance edge + TAPS (TAPS+1 edges counting E0)
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !pv) begin
        if (lat_q.size() == 0) chk("lat_spurious", {15'b0, out_valid}, 16'h0);
        else chk("latency", 16'(edge_cnt - lat_q.pop_front()), 16'(TAPS));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_spurious", {15'b0, out_valid}, 16'h0);
        else chk("out_data", out_data, exp_q.pop_front());
      end
    end
    pv <= out_valid;
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("idle_timeout", {15'b0, in_ready}, 16'h1);
  endtask

  task automatic wr_coef(input logic [AW-1:0] a, input logic [15:0] w);
    wait_idle();
    coef_we = 1; coef_addr = a; coef_wdata = w;
    @(posedge clk); #1;
    coef_we = 0;
    mc[a] = w;
  endtask

  task automatic send_w(input logic [15:0] d, input logic we, input logic [AW-1:0] a,
                        input logic [15:0] w);
    wait_idle();
    in_valid = 1; in_data = d; coef_we = we; coef_addr = a; coef_wdata = w;
    @(posedge clk); #1;
    in_valid = 0; coef_we = 0;
    if (we) mc[a] = w;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = d;
    exp_q.push_back(model_out());
    lat_q.push_back(edge_cnt);
  endtask

  task automatic send(input logic [15:0] d);
    send_w(d, 1'b0, '0, 16'h0);
  endtask

  initial begin
    for (int k = 0; k < TAPS; k++) begin mx[k] = '0; mc[k] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_out_valid", {15'b0, out_valid}, 16'h0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_in_ready", {15'b0, in_ready}, 16'h1);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    send(16'h1234);

    // impulse response
    for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'h4000);
    send(16'h2000);
    for (int i = 0; i < 11; i++) send(16'h0000);

    // wrap-around of the accumulator
    for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'h7FFF);
    for (int i = 0; i < 8; i++) send(16'h7FFF);

    // corner product, coefficient write in the same cycle as acceptance
    for (int k = 1; k < TAPS; k++) wr_coef(AW'(k), 16'h0000);
    send_w(16'h8000, 1'b1, '0, 16'h8000);

    // backpressure with an ignored in_valid pulse
    for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'(16'h1000 * (k + 1)));
    out_ready = 0;
    send(16'h0100);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    chk("bp_valid", {15'b0, out_valid}, 16'h1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", out_data, exp_q[0]);
      chk("bp_in_ready", {15'b0, in_ready}, 16'h0);
      in_valid = (i == 2); in_data = 16'h7777;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    send(16'h0200);

    // coefficient write during MAC is ignored
    send(16'h0400);
    chk("mac_busy", {15'b0, busy}, 16'h1);
    chk("mac_in_ready", {15'b0, in_ready}, 16'h0);
    coef_we = 1; coef_addr = '0; coef_wdata = 16'h7FFF;
    @(posedge clk); #1;
    coef_we = 0;
    send(16'h0300);

    // reset at MAC idx=3
    send(16'h5555);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_out_valid", {15'b0, out_valid}, 16'h0);
    chk("midrst_in_ready", {15'b0, in_ready}, 16'h1);
    chk("midrst_busy", {15'b0, busy}, 16'h0);
    exp_q.delete(); lat_q.delete();
    for (int k = 0; k < TAPS; k++) begin mx[k] = '0; mc[k] = '0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("post_rst_idle", {15'b0, in_ready}, 16'h1);
    chk("post_rst_out_data", out_data, 16'h0);
    wr_coef(AW'(1), 16'h4000);
    send(16'h2000);
    wr_coef(AW'(0), 16'h4000);
    send(16'h0800);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
      chk("drain", 16'(exp_q.size()), 16'h0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
